switch_conditioner: RTL and testbench
=====================================

// Module: switch_conditioner
// PURPOSE
//   Conditions the four raw board switches before they reach the frog movement controller.
//   Per switch: 2-FF synchroniser, then a counter debouncer.
//   Arbitrates the four switches into single-cycle move pulses with hold-to-repeat.
//   Sits between the board pins and the frog module, upstream of frogger.
// PARAMETERS
//   DEBOUNCE_CYCLES  250000    cycles input must differ from stable level before it is accepted (10 ms @25 MHz)
//   REPEAT_DELAY     12500000  cycles from first pulse to first auto-repeat pulse while held (0.5 s)
//   REPEAT_RATE      5000000   cycles between subsequent auto-repeat pulses (0.2 s)
//   CNT_W            24        width of debounce/repeat counters; must hold max(param)-1
// PORTS
//   clk         in   1  system clock
//   reset       in   1  asynchronous, active-high reset
//   switch1     in   1  raw switch, up    (active-high, asynchronous to clk)
//   switch2     in   1  raw switch, down
//   switch3     in   1  raw switch, left
//   switch4     in   1  raw switch, right
//   lock        in   1  sync; high = suppress moves (death/level transition)
//   move_pulse  out  1  one-cycle strobe: frog must move one step
//   move_dir    out  2  direction, valid with move_pulse: 00 up, 01 down, 10 left, 11 right
//   held        out  4  debounced levels {sw4,sw3,sw2,sw1}
// BEHAVIOUR
//   Reset: all sync FFs, stable levels, counters 0; FSM=IDLE.
//     move_pulse=0, move_dir=00, held=4'b0000. Reset mid-operation aborts any hold/repeat immediately.
//   Sync: sync_n <= {sync_n[0], switchN}; sync_n[1] is the only version used downstream.
//   Debounce, per switch:
//     - if sync == stable: cnt <= 0
//     - else if cnt == DEBOUNCE_CYCLES-1: stable <= ~stable, cnt <= 0
//     - else cnt++
//     - held = stable. rise_n = stable & ~stable_q (stable_q: one-cycle delayed copy).
//   Latency: raw change held >= DEBOUNCE_CYCLES+2 cycles -> move_pulse high on edge DEBOUNCE_CYCLES+3.
//   Glitches shorter than DEBOUNCE_CYCLES never change held.
//   FSM states IDLE, HOLD_DELAY, REPEAT; registers owner[1:0], rcnt[CNT_W-1:0].
//   IDLE:
//     - any rise_n and !lock -> pulse, owner/move_dir = highest-priority rising switch (1>2>3>4).
//     - Then rcnt<=0, -> HOLD_DELAY.
//   HOLD_DELAY:
//     - held[owner]==0 -> IDLE, no pulse.
//     - else rcnt==REPEAT_DELAY-1 -> pulse (move_dir=owner), rcnt<=0, -> REPEAT.
//     - else rcnt++.
//   REPEAT: same as HOLD_DELAY using REPEAT_RATE-1; stays in REPEAT.
//   Non-owner switches pressed while owner held are ignored.
//   After owner release they do NOT fire until released and re-pressed (edge required).
//   Same-cycle owner release + other rise: release wins, FSM -> IDLE, that rise is discarded.
//   lock=1: FSM forced to IDLE next edge, move_pulse=0 that cycle; debouncers keep running, held stays live.
//     A switch held across lock deassertion does not fire (edge required).
//   move_pulse is registered and never high two consecutive cycles; move_dir holds last value between pulses.
//   Counters never wrap: compared against param-1 and cleared, so CNT_W overflow is unreachable.
// TESTING  (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=5)
//   Clean press: switch3 0->1 held 30 cycles -> pulses dir=10 at edges 7, 17, 22, 27; held[2]=1 from edge 6.
//   Bounce: switch1 toggles every 2 cycles for 20 cycles then stays 0 -> no pulse, held stays 0.
//   Priority: switch2 and switch4 rise same cycle -> one pulse dir=01; switch4 never fires until re-pressed.
//   Release/other: hold switch4, press switch1 at cycle 12, release switch4 at cycle 20
//     -> only switch4 pulses; switch1 fires dir=00 only after its own release+re-press.
//   Lock: switch2 held, lock=1 for cycles 8-40 -> no pulses during lock, none after (no new edge); held[1]=1.
//   Async reset at cycle 15 of a hold -> outputs 0 within same cycle; press after reset needs full DEBOUNCE_CYCLES+3.

Source files
------------

// File: rtl/switch_conditioner_if.sv
// ============================================================================
// Module  : switch_conditioner_if
// Purpose : Switch/lock inputs and move-strobe outputs between board and frog
//           movement controller.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface switch_conditioner_if;
  logic       switch1;
  logic       switch2;
  logic       switch3;
  logic       switch4;
  logic       lock;
  logic       move_pulse;
  logic [1:0] move_dir;
  logic [3:0] held;

  // Board/stimulus side drives the raw switches and lock.
  modport master (
    output switch1, switch2, switch3, switch4, lock,
    input  move_pulse, move_dir, held
  );

  // Conditioner side.
  modport slave (
    input  switch1, switch2, switch3, switch4, lock,
    output move_pulse, move_dir, held
  );
endinterface

`default_nettype wire

// File: rtl/switch_conditioner.sv
// ============================================================================
// Module  : switch_conditioner
// Purpose : Synchronise and debounce four board switches, arbitrate them into
//           single-cycle move strobes with hold-to-repeat.
// Revision: 1.0
// ============================================================================
`default_nettype none

module switch_conditioner #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_DELAY    = 12500000,
  parameter int REPEAT_RATE     = 5000000,
  parameter int CNT_W           = 24
) (
  input  logic                 clk,
  input  logic                 reset,
  switch_conditioner_if.slave  sw_if
);

  localparam logic [CNT_W-1:0] c_DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] c_RATE_LAST  = CNT_W'(REPEAT_RATE - 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    HOLD_DELAY = 2'd1,
    REPEAT     = 2'd2
  } state_t;

  logic [3:0] w_raw;
  logic [3:0] r_sync0;
  logic [3:0] r_sync1;
  logic [3:0] w_held;
  logic [3:0] r_held_q;
  logic [3:0] w_rise;

  assign w_raw = {sw_if.switch4, sw_if.switch3, sw_if.switch2, sw_if.switch1};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync0  <= 4'b0000;
      r_sync1  <= 4'b0000;
      r_held_q <= 4'b0000;
    end else begin
      r_sync0  <= w_raw;
      r_sync1  <= r_sync0;
      r_held_q <= w_held;
    end
  end

  generate
    for (genvar i = 0; i < 4; i++) begin : g_debounce
      logic             r_stable;
      logic [CNT_W-1:0] r_cnt;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_stable <= 1'b0;
          r_cnt    <= '0;
        end else if (r_sync1[i] == r_stable) begin
          r_cnt <= '0;
        end else if (r_cnt == c_DEB_LAST) begin
          r_stable <= ~r_stable;
          r_cnt    <= '0;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end

      assign w_held[i] = r_stable;
    end
  endgenerate

  assign w_rise = w_held & ~r_held_q;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_owner;
  logic [1:0]       w_owner_nxt;
  logic [CNT_W-1:0] r_rcnt;
  logic [CNT_W-1:0] w_rcnt_nxt;
  logic             r_pulse;
  logic             w_pulse_nxt;
  logic [1:0]       r_dir;
  logic [1:0]       w_dir_nxt;
  logic [1:0]       w_first;
  logic [CNT_W-1:0] w_limit;

  // Lowest-numbered switch wins when several rise together.
  always_comb begin
    w_first = 2'd3;
    if (w_rise[0])      w_first = 2'd0;
    else if (w_rise[1]) w_first = 2'd1;
    else if (w_rise[2]) w_first = 2'd2;
  end

  assign w_limit = (r_state == REPEAT) ? c_RATE_LAST : c_DELAY_LAST;

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_rcnt_nxt  = r_rcnt;
    w_pulse_nxt = 1'b0;
    w_dir_nxt   = r_dir;
    if (sw_if.lock) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (|w_rise) begin
            w_pulse_nxt = 1'b1;
            w_owner_nxt = w_first;
            w_dir_nxt   = w_first;
            w_rcnt_nxt  = '0;
            w_state_nxt = HOLD_DELAY;
          end
        end
        HOLD_DELAY, REPEAT: begin
          // Owner release takes precedence over anything else this cycle.
          if (!w_held[r_owner]) begin
            w_state_nxt = IDLE;
          end else if (r_rcnt == w_limit) begin
            w_pulse_nxt = 1'b1;
            w_dir_nxt   = r_owner;
            w_rcnt_nxt  = '0;
            w_state_nxt = REPEAT;
          end else begin
            w_rcnt_nxt = r_rcnt + CNT_W'(1);
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_owner <= 2'd0;
      r_rcnt  <= '0;
      r_pulse <= 1'b0;
      r_dir   <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_rcnt  <= w_rcnt_nxt;
      r_pulse <= w_pulse_nxt;
      r_dir   <= w_dir_nxt;
    end
  end

  assign sw_if.move_pulse = r_pulse;
  assign sw_if.move_dir   = r_dir;
  assign sw_if.held       = w_held;

endmodule

`default_nettype wire

// File: tb/tb_switch_conditioner.sv
// Randomised bench for switch_conditioner: every cycle the outputs are compared
// against a run-length / pulse-schedule reference model.
`default_nettype none

module tb_switch_conditioner;

  localparam int DEB = 4;
  localparam int RD  = 10;
  localparam int RR  = 5;

  logic clk = 1'b0;
  logic reset;

  switch_conditioner_if sw_if ();

  switch_conditioner #(
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY   (RD),
    .REPEAT_RATE    (RR),
    .CNT_W          (8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .sw_if(sw_if)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, obs, exp);
    end
  endtask

  // Reference model state: pipeline taps, run lengths of disagreement,
  // and a pulse schedule (who owns the press, how long since its last pulse).
  logic [3:0] m_p0, m_p1, m_held, m_held_d;
  int         m_run [4];
  bit         m_active;
  int         m_owner, m_since, m_npulse;
  bit         m_pulse;
  logic [1:0] m_dir;

  task automatic model_reset();
    m_p0 = '0; m_p1 = '0; m_held = '0; m_held_d = '0;
    for (int i = 0; i < 4; i++) m_run[i] = 0;
    m_active = 0; m_owner = 0; m_since = 0; m_npulse = 0;
    m_pulse = 0; m_dir = 2'b00;
  endtask

  task automatic model_step(input logic [3:0] raw, input bit lk);
    logic [3:0] sync_old, held_old, rise;
    sync_old = m_p1;
    held_old = m_held;
    rise     = m_held & ~m_held_d;
    m_p1 = m_p0;
    m_p0 = raw;
    m_held_d = held_old;
    for (int i = 0; i < 4; i++) begin
      if (sync_old[i] != held_old[i]) begin
        m_run[i]++;
        if (m_run[i] == DEB) begin
          m_held[i] = ~m_held[i];
          m_run[i]  = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    m_pulse = 0;
    if (lk) begin
      m_active = 0;
    end else if (m_active) begin
      if (!held_old[m_owner]) begin
        m_active = 0;
      end else begin
        m_since++;
        if (m_since == ((m_npulse == 1) ? RD : RR)) begin
          m_pulse = 1;
          m_dir   = 2'(m_owner);
          m_since = 0;
          m_npulse++;
        end
      end
    end else if (rise != 4'b0000) begin
      for (int i = 3; i >= 0; i--) if (rise[i]) m_owner = i;
      m_pulse  = 1;
      m_dir    = 2'(m_owner);
      m_active = 1;
      m_since  = 0;
      m_npulse = 1;
    end
  endtask

  task automatic compare_outputs(input string where);
    check_val({where, ".pulse"}, 32'(sw_if.move_pulse), 32'(m_pulse));
    check_val({where, ".dir"},   32'(sw_if.move_dir),   32'(m_dir));
    check_val({where, ".held"},  32'(sw_if.held),       32'(m_held));
  endtask

  task automatic step(input logic [3:0] raw, input bit lk);
    @(negedge clk);
    sw_if.switch1 = raw[0];
    sw_if.switch2 = raw[1];
    sw_if.switch3 = raw[2];
    sw_if.switch4 = raw[3];
    sw_if.lock    = lk;
    @(posedge clk);
    #1;
    model_step(raw, lk);
    compare_outputs("cyc");
  endtask

  task automatic hold(input logic [3:0] raw, input bit lk, input int n);
    for (int k = 0; k < n; k++) step(raw, lk);
  endtask

  // Asynchronous reset asserted between edges: outputs must clear at once.
  task automatic async_reset();
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    compare_outputs("async_rst");
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    sw_if.switch1 = 0; sw_if.switch2 = 0; sw_if.switch3 = 0; sw_if.switch4 = 0;
    sw_if.lock = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_outputs("reset");
    reset = 1'b0;

    // Clean press of switch3, then both-sides priority, then a bounce.
    hold(4'b0100, 0, 30);
    hold(4'b0000, 0, 10);
    hold(4'b1010, 0, 25);
    hold(4'b1000, 0, 10);
    hold(4'b0000, 0, 10);
    for (int k = 0; k < 10; k++) hold((k % 2) ? 4'b0000 : 4'b0001, 0, 2);
    hold(4'b0000, 0, 10);
    // Owner switch4 held while switch1 joins, then owner released.
    hold(4'b1000, 0, 12);
    hold(4'b1001, 0, 8);
    hold(4'b0001, 0, 15);
    hold(4'b0000, 0, 8);
    hold(4'b0001, 0, 12);
    hold(4'b0000, 0, 8);
    // Lock across a hold.
    hold(4'b0010, 0, 8);
    hold(4'b0010, 1, 33);
    hold(4'b0010, 0, 20);
    hold(4'b0000, 0, 8);
    // Reset in the middle of a hold, then a fresh press.
    hold(4'b0100, 0, 15);
    async_reset();
    hold(4'b0100, 0, 20);
    hold(4'b0000, 0, 8);

    // Randomised segments: random switch subsets, durations and lock.
    for (int seg = 0; seg < 200; seg++) begin
      logic [3:0] raw;
      bit         lk;
      int         len;
      raw = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) raw = 4'b0000;
      lk  = ($urandom_range(0, 9) == 0);
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(15, 45) : $urandom_range(1, 8);
      hold(raw, lk, len);
      if ($urandom_range(0, 60) == 0) async_reset();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
